// File: rtl/display_pkg.sv
// Shared constants and types for the display frame streamer.
package display_pkg;

   localparam int unsigned PIX_W     = 16;
   localparam int unsigned DEF_X_RES = 480;
   localparam int unsigned DEF_Y_RES = 320;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

endpackage

// File: rtl/display_frame_streamer_sync_fifo.sv
// Single-clock FIFO with registered read data (one-cycle read latency).
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 32
) (
   input  logic                     aclk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] dout_q;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign count   = count_q;
   assign dout    = dout_q;

   always_ff @(posedge aclk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            dout_q   <= mem_q[rd_ptr_q];
         end
         count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/display_frame_streamer.sv
// Streams one framebuffer from an AXI4 read master out as a 16-bit AXI-Stream pixel stream.
module display_frame_streamer
   import display_pkg::*;
#(
   parameter int unsigned MEM_DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned X_RES          = DEF_X_RES,
   parameter int unsigned Y_RES          = DEF_Y_RES,
   parameter int unsigned BURST_LEN      = 16,
   parameter int unsigned FIFO_DEPTH     = 32
) (
   input  logic                      aclk,
   input  logic                      resetn,
   input  logic                      start,
   input  logic [ADDR_WIDTH-1:0]     base_addr,
   output logic                      busy,
   output logic                      done,
   output logic                      rd_error,
   output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic [7:0]                m_axi_arlen,
   output logic [2:0]                m_axi_arsize,
   output logic [1:0]                m_axi_arburst,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [MEM_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rlast,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tlast,
   output logic [15:0]               m_axis_tdata
);

   localparam int unsigned PPW          = MEM_DATA_WIDTH / PIX_W;
   localparam int unsigned TOTAL_PIX    = X_RES * Y_RES;
   localparam int unsigned TOTAL_BEATS  = TOTAL_PIX / PPW;
   localparam int unsigned TOTAL_BURSTS = TOTAL_BEATS / BURST_LEN;
   localparam int unsigned BURST_BYTES  = BURST_LEN * MEM_DATA_WIDTH / 8;
   localparam int unsigned SUB_W        = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int unsigned PIX_CNT_W    = $clog2(TOTAL_PIX + 1);
   localparam int unsigned BURST_CNT_W  = $clog2(TOTAL_BURSTS + 1);
   localparam int unsigned OUT_W        = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned FCNT_W       = $clog2(FIFO_DEPTH) + 1;

   state_e                    state_q;
   logic                      busy_q, done_q, rd_error_q;
   logic [ADDR_WIDTH-1:0]     araddr_q;
   logic                      arvalid_q;
   logic [BURST_CNT_W-1:0]    bursts_q;
   logic [OUT_W-1:0]          outst_q;
   logic [MEM_DATA_WIDTH-1:0] word_q;
   logic [SUB_W-1:0]          sub_q;
   logic                      tvalid_q, tlast_q;
   logic [PIX_W-1:0]          tdata_q;
   logic                      dout_vld_q;
   logic [PIX_CNT_W-1:0]      pix_q;

   logic [MEM_DATA_WIDTH-1:0] fifo_dout;
   logic [FCNT_W-1:0]         fifo_count;
   logic                      fifo_empty, fifo_full_unused, fifo_pop;
   logic                      ar_hs, credit_ok, last_sub, advance_sub, take_word, last_pix;
   logic                      rlast_unused;

   assign rlast_unused = m_axi_rlast;

   sync_fifo #(
      .WIDTH (MEM_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .aclk   (aclk),
      .resetn (resetn),
      .push   (m_axi_rvalid),
      .din    (m_axi_rdata),
      .pop    (fifo_pop),
      .dout   (fifo_dout),
      .count  (fifo_count),
      .empty  (fifo_empty),
      .full   (fifo_full_unused)
   );

   // A burst may only be requested if every beat already owed to us still fits.
   assign ar_hs     = arvalid_q && m_axi_arready;
   assign credit_ok = (32'(fifo_count) + 32'(outst_q) + BURST_LEN) <= FIFO_DEPTH;

   // The FIFO word is prefetched into dout so a new word is ready the cycle the last sub-pixel leaves.
   assign last_sub    = (sub_q == SUB_W'(PPW - 1));
   assign advance_sub = tvalid_q && m_axis_tready && !last_sub;
   assign take_word   = dout_vld_q && (!tvalid_q || (m_axis_tready && last_sub));
   assign fifo_pop    = !fifo_empty && (!dout_vld_q || take_word);
   assign last_pix    = (pix_q == PIX_CNT_W'(TOTAL_PIX - 1));

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_error_q <= 1'b0;
         araddr_q   <= '0;
         arvalid_q  <= 1'b0;
         bursts_q   <= '0;
         outst_q    <= '0;
         word_q     <= '0;
         sub_q      <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         tdata_q    <= '0;
         dout_vld_q <= 1'b0;
         pix_q      <= '0;
      end else begin
         done_q  <= 1'b0;
         outst_q <= outst_q + (ar_hs ? OUT_W'(BURST_LEN) : '0) - OUT_W'(m_axi_rvalid);
         if (m_axi_rvalid && (m_axi_rresp != RESP_OKAY)) rd_error_q <= 1'b1;

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q    <= ST_RUN;
                  busy_q     <= 1'b1;
                  araddr_q   <= base_addr;
                  rd_error_q <= 1'b0;
                  bursts_q   <= '0;
                  pix_q      <= '0;
               end
            end
            ST_RUN: begin
               if (arvalid_q) begin
                  if (m_axi_arready) begin
                     arvalid_q <= 1'b0;
                     araddr_q  <= araddr_q + ADDR_WIDTH'(BURST_BYTES);
                     bursts_q  <= bursts_q + BURST_CNT_W'(1);
                  end
               end else if ((bursts_q < BURST_CNT_W'(TOTAL_BURSTS)) && credit_ok) begin
                  arvalid_q <= 1'b1;
               end
               if (tvalid_q && m_axis_tready && tlast_q) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         // Serializer: lowest 16-bit half of each word first.
         if (advance_sub) begin
            sub_q   <= sub_q + SUB_W'(1);
            tdata_q <= PIX_W'(word_q >> (PIX_W * (32'(sub_q) + 32'd1)));
            tlast_q <= last_pix;
            pix_q   <= pix_q + PIX_CNT_W'(1);
         end else if (take_word) begin
            word_q   <= fifo_dout;
            sub_q    <= '0;
            tdata_q  <= fifo_dout[PIX_W-1:0];
            tvalid_q <= 1'b1;
            tlast_q  <= last_pix;
            pix_q    <= pix_q + PIX_CNT_W'(1);
         end else if (tvalid_q && m_axis_tready) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
         end

         if (fifo_pop)       dout_vld_q <= 1'b1;
         else if (take_word) dout_vld_q <= 1'b0;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign rd_error      = rd_error_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = 8'(BURST_LEN - 1);
   assign m_axi_arsize  = 3'($clog2(MEM_DATA_WIDTH / 8));
   assign m_axi_arburst = BURST_INCR;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = 1'b1;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tdata  = tdata_q;

endmodule

// File: tb/tb_display_frame_streamer.sv
// Directed bench: 8x4 frame, 32-bit memory, 4-beat bursts, 8-deep FIFO, with a simple AXI memory model.
module tb_display_frame_streamer;

   localparam int unsigned MDW = 32;
   localparam int unsigned AW  = 32;
   localparam int unsigned XR  = 8;
   localparam int unsigned YR  = 4;
   localparam int unsigned BL  = 4;
   localparam int unsigned FD  = 8;

   logic            aclk = 1'b0;
   logic            resetn;
   logic            start;
   logic [AW-1:0]   base_addr;
   logic            busy, done, rd_error;
   logic [AW-1:0]   m_axi_araddr;
   logic [7:0]      m_axi_arlen;
   logic [2:0]      m_axi_arsize;
   logic [1:0]      m_axi_arburst;
   logic            m_axi_arvalid;
   logic            m_axi_arready;
   logic [MDW-1:0]  m_axi_rdata;
   logic [1:0]      m_axi_rresp;
   logic            m_axi_rlast;
   logic            m_axi_rvalid;
   logic            m_axi_rready;
   logic            m_axis_tvalid;
   logic            m_axis_tready;
   logic            m_axis_tlast;
   logic [15:0]     m_axis_tdata;

   display_frame_streamer #(
      .MEM_DATA_WIDTH (MDW),
      .ADDR_WIDTH     (AW),
      .X_RES          (XR),
      .Y_RES          (YR),
      .BURST_LEN      (BL),
      .FIFO_DEPTH     (FD)
   ) dut (
      .aclk          (aclk),
      .resetn        (resetn),
      .start         (start),
      .base_addr     (base_addr),
      .busy          (busy),
      .done          (done),
      .rd_error      (rd_error),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arsize  (m_axi_arsize),
      .m_axi_arburst (m_axi_arburst),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rlast   (m_axi_rlast),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tdata  (m_axis_tdata)
   );

   always #5 aclk = ~aclk;

   int tests = 0;
   int fails = 0;

   logic [31:0] ar_q[$];
   logic [31:0] ar_log[$];
   logic [15:0] pix_log[$];
   int          tlast_pos[$];
   int unsigned beats_left = 0;
   logic [31:0] cur_addr = '0;
   bit          rand_mem = 1'b0, rand_rdy = 1'b0, hold_rdy = 1'b0, err_en = 1'b0;
   int          done_cnt = 0, cyc = 0, last_hs_cyc = -1, done_cyc = -100;
   int          ovf_cnt = 0, arfield_bad = 0;

   // Monitor: samples handshakes at the active edge, before the DUT updates.
   always @(posedge aclk) begin
      if (!resetn) begin
         ar_q.delete();
         beats_left = 0;
      end else begin
         if (m_axi_arvalid && m_axi_arready) begin
            ar_q.push_back(m_axi_araddr);
            ar_log.push_back(m_axi_araddr);
            if (m_axi_arlen !== 8'd3 || m_axi_arsize !== 3'd2 || m_axi_arburst !== 2'b01) arfield_bad++;
         end
         if (m_axi_rvalid) begin
            if (dut.u_fifo.full) ovf_cnt++;
            cur_addr   = cur_addr + 32'd4;
            beats_left = beats_left - 1;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            pix_log.push_back(m_axis_tdata);
            if (m_axis_tlast) begin
               tlast_pos.push_back(pix_log.size() - 1);
               last_hs_cyc = cyc;
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
      cyc++;
   end

   // Memory and sink model: drives the next cycle's inputs on the falling edge.
   always @(negedge aclk) begin
      int unsigned idx;
      m_axis_tready = hold_rdy ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      m_axi_arready = rand_mem ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_rvalid  = 1'b0;
      m_axi_rlast   = 1'b0;
      m_axi_rresp   = 2'b00;
      if (resetn) begin
         if (beats_left == 0 && ar_q.size() > 0) begin
            cur_addr   = ar_q.pop_front();
            beats_left = BL;
         end
         if (beats_left > 0 && (!rand_mem || $urandom_range(0, 1) == 1)) begin
            idx          = (cur_addr & 32'hFFF) >> 2;
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = {16'(2 * idx + 1), 16'(2 * idx)};
            m_axi_rlast  = (beats_left == 1);
            m_axi_rresp  = (err_en && idx == 5) ? 2'b10 : 2'b00;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      ar_log.delete();
      pix_log.delete();
      tlast_pos.delete();
      done_cnt    = 0;
      last_hs_cyc = -1;
      done_cyc    = -100;
      arfield_bad = 0;
   endtask

   task automatic pulse_start(input logic [31:0] a);
      base_addr = a;
      start     = 1'b1;
      @(negedge aclk);
      start     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge aclk);
         n++;
      end
      check({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
      repeat (3) @(negedge aclk);
   endtask

   task automatic check_frame(input string tag, input logic [31:0] base);
      int bad;
      int tl;
      check({tag, "_ar_cnt"}, 32'(ar_log.size()), 32'd4);
      bad = 0;
      for (int k = 0; k < ar_log.size(); k++)
         if (ar_log[k] !== base + 32'(16 * k)) bad++;
      check({tag, "_ar_addr_bad"}, 32'(bad), 32'd0);
      check({tag, "_ar_fields_bad"}, 32'(arfield_bad), 32'd0);
      check({tag, "_pix_cnt"}, 32'(pix_log.size()), 32'd32);
      bad = 0;
      for (int k = 0; k < pix_log.size(); k++)
         if (pix_log[k] !== 16'(k)) bad++;
      check({tag, "_pix_order_bad"}, 32'(bad), 32'd0);
      tl = (tlast_pos.size() > 0) ? tlast_pos[0] : -1;
      check({tag, "_tlast_cnt"}, 32'(tlast_pos.size()), 32'd1);
      check({tag, "_tlast_pos"}, 32'(tl), 32'd31);
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_done_lag"}, 32'(done_cyc - last_hs_cyc), 32'd1);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      resetn    = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      repeat (3) @(negedge aclk);
      check("rst_ctrl", {26'd0, m_axi_arvalid, m_axis_tvalid, m_axis_tlast, busy, done, rd_error}, 32'd0);
      check("rst_araddr", m_axi_araddr, 32'd0);
      check("rst_tdata", 32'(m_axis_tdata), 32'd0);
      check("rready_high", 32'(m_axi_rready), 32'd1);
      resetn = 1'b1;
      repeat (2) @(negedge aclk);

      // 1: basic frame
      clear_logs();
      pulse_start(32'h1000);
      check("s1_busy", 32'(busy), 32'd1);
      wait_done("s1", 500);
      check_frame("s1", 32'h1000);

      // 2: display backpressure throttles bursts via credit
      clear_logs();
      hold_rdy = 1'b1;
      @(negedge aclk);
      pulse_start(32'h1000);
      repeat (60) @(negedge aclk);
      check("s2_ar_stalled", 32'(ar_log.size()), 32'd2);
      check("s2_arvalid_low", 32'(m_axi_arvalid), 32'd0);
      check("s2_tvalid_held", 32'(m_axis_tvalid), 32'd1);
      check("s2_tdata_held", 32'(m_axis_tdata), 32'd0);
      hold_rdy = 1'b0;
      wait_done("s2", 500);
      check_frame("s2", 32'h1000);

      // 3: random stalls on every channel
      clear_logs();
      ovf_cnt  = 0;
      rand_mem = 1'b1;
      rand_rdy = 1'b1;
      pulse_start(32'h1000);
      wait_done("s3", 2000);
      check_frame("s3", 32'h1000);
      check("s3_no_overflow", 32'(ovf_cnt), 32'd0);
      rand_mem = 1'b0;
      rand_rdy = 1'b0;
      repeat (2) @(negedge aclk);

      // 4: start while busy is ignored, then a fresh frame elsewhere
      clear_logs();
      pulse_start(32'h1000);
      repeat (6) @(negedge aclk);
      pulse_start(32'h3000);
      wait_done("s4a", 500);
      repeat (10) @(negedge aclk);
      check_frame("s4a", 32'h1000);
      clear_logs();
      pulse_start(32'h2000);
      wait_done("s4b", 500);
      check_frame("s4b", 32'h2000);

      // 5: error response on beat 5
      clear_logs();
      err_en = 1'b1;
      pulse_start(32'h1000);
      wait_done("s5", 500);
      check_frame("s5", 32'h1000);
      check("s5_pix10", (pix_log.size() > 11) ? 32'(pix_log[10]) : 32'hDEAD, 32'd10);
      check("s5_pix11", (pix_log.size() > 11) ? 32'(pix_log[11]) : 32'hDEAD, 32'd11);
      check("s5_rd_error_set", 32'(rd_error), 32'd1);
      repeat (5) @(negedge aclk);
      check("s5_rd_error_sticky", 32'(rd_error), 32'd1);
      err_en = 1'b0;
      clear_logs();
      pulse_start(32'h1000);
      check("s5_rd_error_clr", 32'(rd_error), 32'd0);
      wait_done("s5b", 500);
      check_frame("s5b", 32'h1000);
      check("s5b_rd_error", 32'(rd_error), 32'd0);

      // 6: reset mid-frame
      clear_logs();
      pulse_start(32'h1000);
      n = 0;
      while (ar_log.size() < 2 && n < 200) begin
         @(negedge aclk);
         n++;
      end
      check("s6_two_bursts", 32'(ar_log.size() >= 2), 32'd1);
      resetn = 1'b0;
      @(negedge aclk);
      check("s6_rst_ctrl", {26'd0, m_axi_arvalid, m_axis_tvalid, m_axis_tlast, busy, done, rd_error}, 32'd0);
      check("s6_rst_araddr", m_axi_araddr, 32'd0);
      check("s6_rst_tdata", 32'(m_axis_tdata), 32'd0);
      @(negedge aclk);
      resetn = 1'b1;
      repeat (2) @(negedge aclk);
      clear_logs();
      pulse_start(32'h1000);
      wait_done("s6", 500);
      check_frame("s6", 32'h1000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
